// File: rtl/uart_cmd_frame_scheduler_pkg.sv
// Shared constants, state encoding and frame-length helper for the UART command frame scheduler.
package uart_cmd_frame_scheduler_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CH_W   = 10;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SNAP_W = NUM_CH * CH_W;
  localparam int unsigned IDX_W  = 4;

  localparam logic [BYTE_W-1:0] OP_RD_CH1 = 8'h01;
  localparam logic [BYTE_W-1:0] OP_RD_CH2 = 8'h02;
  localparam logic [BYTE_W-1:0] OP_RD_CH3 = 8'h03;
  localparam logic [BYTE_W-1:0] OP_RD_CH4 = 8'h04;
  localparam logic [BYTE_W-1:0] OP_RD_ALL = 8'h05;
  localparam logic [BYTE_W-1:0] OP_CLR    = 8'h10;

  localparam logic [BYTE_W-1:0] HDR_DEFAULT = 8'hA5;
  localparam logic [BYTE_W-1:0] NAK_DEFAULT = 8'h15;

  // Total frame lengths: header + opcode + payload + checksum
  localparam logic [IDX_W-1:0] LEN_RD_CH  = 4'd5;
  localparam logic [IDX_W-1:0] LEN_RD_ALL = 4'd11;
  localparam logic [IDX_W-1:0] LEN_CLR    = 4'd3;
  localparam logic [IDX_W-1:0] LEN_NAK    = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  // Number of bytes in the response frame for a given opcode
  function automatic logic [IDX_W-1:0] frame_len(input logic [BYTE_W-1:0] op);
    if (op >= OP_RD_CH1 && op <= OP_RD_CH4) return LEN_RD_CH;
    else if (op == OP_RD_ALL)               return LEN_RD_ALL;
    else if (op == OP_CLR)                  return LEN_CLR;
    else                                    return LEN_NAK;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_scheduler_frame_byte_mux.sv
// Selects the frame byte at a given index: header, opcode echo, payload from the snapshot, or checksum.
module frame_byte_mux
  import uart_cmd_frame_scheduler_pkg::*;
(
  input  logic [BYTE_W-1:0] hdr_byte_i,
  input  logic [BYTE_W-1:0] nak_byte_i,
  input  logic [BYTE_W-1:0] opcode_i,
  input  logic [SNAP_W-1:0] snap_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [IDX_W-1:0]  len_i,
  input  logic [BYTE_W-1:0] csum_i,
  output logic [BYTE_W-1:0] byte_o
);

  logic [IDX_W-1:0] pidx;
  logic [1:0]       ch_sel;
  logic             hi_sel;
  logic [CH_W-1:0]  ch_val;
  logic [BYTE_W-1:0] payload;
  logic             is_rd_ch;
  logic             is_rd_all;

  // Payload byte decode followed by position-based byte select
  always_comb begin
    is_rd_ch  = (opcode_i >= OP_RD_CH1) && (opcode_i <= OP_RD_CH4);
    is_rd_all = (opcode_i == OP_RD_ALL);
    pidx      = idx_i - IDX_W'(2);
    ch_sel    = 2'(opcode_i - 8'd1);
    hi_sel    = (pidx == '0);
    if (is_rd_all) begin
      ch_sel = pidx[2:1];
      hi_sel = ~pidx[0];
    end
    ch_val  = snap_i[32'(ch_sel) * CH_W +: CH_W];
    payload = hi_sel ? {6'b0, ch_val[9:8]} : ch_val[7:0];

    byte_o = hdr_byte_i;
    if (idx_i == '0)                      byte_o = hdr_byte_i;
    else if (idx_i == IDX_W'(1))          byte_o = opcode_i;
    else if (idx_i == len_i - IDX_W'(1))  byte_o = csum_i;
    else if (is_rd_ch || is_rd_all)       byte_o = payload;
    else                                  byte_o = nak_byte_i;
  end

endmodule

// File: rtl/uart_cmd_frame_scheduler.sv
// Decodes a UART opcode, snapshots channel maxima and sends a framed, checksummed response byte by byte.
module uart_cmd_frame_scheduler
  import uart_cmd_frame_scheduler_pkg::*;
#(
  parameter int unsigned       ACK_TIMEOUT = 1024,
  parameter logic [BYTE_W-1:0] HDR_BYTE    = HDR_DEFAULT,
  parameter logic [BYTE_W-1:0] NAK_BYTE    = NAK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic [SNAP_W-1:0] ch_value,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_en,
  output logic              tx_write_en,
  output logic              cache_clear,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        drop_count
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q;
  logic [BYTE_W-1:0] opcode_q;
  logic [SNAP_W-1:0] snap_q;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BYTE_W-1:0] csum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_en_q;
  logic              cache_clear_q;
  logic              busy_q;
  logic              err_q;
  logic [7:0]        drop_q;
  logic [BYTE_W-1:0] mux_byte;

  frame_byte_mux u_frame_byte_mux (
    .hdr_byte_i (HDR_BYTE),
    .nak_byte_i (NAK_BYTE),
    .opcode_i   (opcode_q),
    .snap_i     (snap_q),
    .idx_i      (idx_q),
    .len_i      (len_q),
    .csum_i     (csum_q),
    .byte_o     (mux_byte)
  );

  // Frame sequencer: decode, per-byte load/strobe/handshake, ack timeout
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      snap_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      tmo_q         <= '0;
      tx_data_q     <= '0;
      tx_en_q       <= 1'b0;
      cache_clear_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      tx_en_q       <= 1'b0;
      cache_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_ready) begin
            opcode_q <= rx_data;
            busy_q   <= 1'b1;
            state_q  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          snap_q        <= ch_value;
          len_q         <= frame_len(opcode_q);
          idx_q         <= '0;
          csum_q        <= '0;
          cache_clear_q <= (opcode_q == OP_CLR);
          state_q       <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_q <= mux_byte;
          if (tx_ready) begin
            tx_en_q <= 1'b1;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          csum_q  <= csum_q ^ tx_data_q;
          tmo_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            state_q <= ST_WAIT_DONE;
          end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            if (idx_q == len_q - IDX_W'(1)) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_LOAD;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of opcodes arriving outside IDLE
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      drop_q <= '0;
    end else if (rx_ready && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_en       = tx_en_q;
  assign tx_write_en = tx_en_q;
  assign cache_clear = cache_clear_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign drop_count  = drop_q;

endmodule
